// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
// Pipeline sequencing controller for a 5-stage CPU.
// It handles three kinds of event:
//   - load-use hazards that forwarding cannot cover (one-cycle stall + bubble)
//   - multi-cycle data-memory accesses (full pipeline freeze)
//   - taken branches (flush of the wrong-path IF/ID and ID/EX contents)
// It also provides program halt, a memory-timeout trap and saturating
// stall/flush performance counters.
// Control outputs are combinational from the registered state and the
// current inputs, so a control decision takes effect in the same cycle.
// The halt and timeout flags and the counters are registered.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module hazard_controller #(
    parameter int REG_W       = 4,
    parameter int R0_ZERO     = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_reg_dst,
    input  logic             ex_wr,
    input  logic             ex_mem_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             wb_halt,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    // The wait counter is 8 bits wide, so the timeout limit must fit in 8 bits.
    localparam int         WAIT_W  = 8;
    localparam logic [WAIT_W-1:0] TMO_LIM = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    // A limit of 0 or 1 means the very first frozen cycle already times out.
    localparam logic       TMO_IMMEDIATE = (MEM_TIMEOUT <= 1) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_halted;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_flush_count;

    logic              w_freeze;
    logic              w_dst_is_zero;
    logic              w_rs1_hit;
    logic              w_rs2_hit;
    logic              w_load_use;
    logic [WAIT_W-1:0] w_wait_inc;
    logic              w_wait_expired;

    // Hazard detection: load in EX whose destination feeds an ID source.
    always_comb begin
        w_dst_is_zero = 1'b0;
        w_rs1_hit     = 1'b0;
        w_rs2_hit     = 1'b0;
        w_load_use    = 1'b0;
        if (R0_ZERO != 0) begin
            w_dst_is_zero = (ex_reg_dst == {REG_W{1'b0}});
        end else begin
            w_dst_is_zero = 1'b0;
        end
        w_rs1_hit  = id_rs1_used && (id_rs1 == ex_reg_dst);
        w_rs2_hit  = id_rs2_used && (id_rs2 == ex_reg_dst);
        w_load_use = ex_mem_rd && ex_wr && !w_dst_is_zero && (w_rs1_hit || w_rs2_hit);
    end

    // Freeze condition and wait-counter arithmetic for the memory-wait path.
    always_comb begin
        w_freeze       = 1'b0;
        w_wait_inc     = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        w_wait_expired = 1'b0;
        if (r_state != ST_HALT) begin
            w_freeze = mem_req && !mem_ready;
        end else begin
            w_freeze = 1'b0;
        end
        w_wait_expired = (w_wait_inc >= TMO_LIM);
    end

    // Pipeline control outputs: halt and freeze dominate, then branch, then load-use.
    always_comb begin
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;
        if ((r_state == ST_HALT) || w_freeze) begin
            // Whole pipeline holds; a taken branch waits in the frozen EX stage.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            // Any dependent instruction behind the branch is wrong-path anyway.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
        end else if (w_load_use) begin
            // One bubble lets the load reach MEM, where forwarding covers it.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_flush   = 1'b1;
        end else begin
            pc_stall      = 1'b0;
            if_id_stall   = 1'b0;
        end
    end

    // Sequencing FSM with wait counter, halt flag and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= {WAIT_W{1'b0}};
            r_halted      <= 1'b0;
            r_mem_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (wb_halt) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                    end else if (w_freeze) begin
                        if (TMO_IMMEDIATE) begin
                            r_state       <= ST_HALT;
                            r_halted      <= 1'b1;
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_state       <= ST_MEM_WAIT;
                        end
                        r_wait_cnt <= {{(WAIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end
                end
                ST_MEM_WAIT: begin
                    if (wb_halt) begin
                        r_state    <= ST_HALT;
                        r_halted   <= 1'b1;
                    end else if (w_freeze) begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_wait_expired) begin
                            r_state       <= ST_HALT;
                            r_halted      <= 1'b1;
                            r_mem_timeout <= 1'b1;
                        end else begin
                            r_state       <= ST_MEM_WAIT;
                        end
                    end else begin
                        // Access completed (or was withdrawn): back to normal flow.
                        r_state    <= ST_RUN;
                        r_wait_cnt <= {WAIT_W{1'b0}};
                    end
                end
                ST_HALT: begin
                    // Only reset leaves HALT.
                    r_state    <= ST_HALT;
                    r_halted   <= 1'b1;
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_wait_cnt <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Saturating performance counters; frozen in HALT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= {CNT_W{1'b0}};
            r_flush_count  <= {CNT_W{1'b0}};
        end else begin
            if ((r_state != ST_HALT) && pc_stall && (r_stall_cycles != CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if ((r_state != ST_HALT) && if_id_flush && (r_flush_count != CNT_MAX)) begin
                r_flush_count <= r_flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                r_flush_count <= r_flush_count;
            end
        end
    end

    assign halted       = r_halted;
    assign mem_timeout  = r_mem_timeout;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
// Counters are built narrow so that saturation is reached quickly.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_controller;

    localparam int REG_W   = 4;
    localparam int CNT_W   = 6;
    localparam int TMO     = 255;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_reg_dst;
    logic             id_rs1_used, id_rs2_used, ex_wr, ex_mem_rd;
    logic             ex_branch_taken, mem_req, mem_ready, wb_halt;
    logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic             id_ex_flush, ex_mem_stall, mem_wb_bubble, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model state
    bit m_halt;
    bit m_tmo;
    int m_wait;
    int m_stc;
    int m_flc;

    hazard_controller #(.REG_W(REG_W), .R0_ZERO(1), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_reg_dst(ex_reg_dst), .ex_wr(ex_wr), .ex_mem_rd(ex_mem_rd),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_halt(wb_halt),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_reg_dst = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_wr = 1'b0; ex_mem_rd = 1'b0;
        ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic model_reset();
        m_halt = 0; m_tmo = 0; m_wait = 0; m_stc = 0; m_flc = 0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        bit frz, lu, e_stall, e_flush, e_lu;
        #1;
        frz = !m_halt && mem_req && !mem_ready;
        lu  = ex_mem_rd && ex_wr && (ex_reg_dst != 0) &&
              ((id_rs1_used && id_rs1 == ex_reg_dst) || (id_rs2_used && id_rs2 == ex_reg_dst));
        e_stall = m_halt || frz;
        e_flush = !e_stall && ex_branch_taken;
        e_lu    = !e_stall && !ex_branch_taken && lu;
        check("pc_stall",      {31'd0, pc_stall},      {31'd0, e_stall | e_lu});
        check("if_id_stall",   {31'd0, if_id_stall},   {31'd0, e_stall | e_lu});
        check("if_id_flush",   {31'd0, if_id_flush},   {31'd0, e_flush});
        check("id_ex_stall",   {31'd0, id_ex_stall},   {31'd0, e_stall});
        check("id_ex_flush",   {31'd0, id_ex_flush},   {31'd0, e_flush | e_lu});
        check("ex_mem_stall",  {31'd0, ex_mem_stall},  {31'd0, e_stall});
        check("mem_wb_bubble", {31'd0, mem_wb_bubble}, {31'd0, e_stall});
        check("halted",        {31'd0, halted},        {31'd0, m_halt});
        check("mem_timeout",   {31'd0, mem_timeout},   {31'd0, m_tmo});
        check("stall_cycles",  {26'd0, stall_cycles},  m_stc);
        check("flush_count",   {26'd0, flush_count},   m_flc);
        @(posedge clk);
        if (!m_halt) begin
            if ((e_stall || e_lu) && m_stc < CNT_MAX) m_stc++;
            if (e_flush && m_flc < CNT_MAX) m_flc++;
            if (wb_halt) begin
                m_halt = 1;
            end else if (frz) begin
                m_wait++;
                if (m_wait >= TMO) begin
                    m_halt = 1;
                    m_tmo  = 1;
                end
            end else begin
                m_wait = 0;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear at once.
    task automatic do_reset();
        idle();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_halted",  {31'd0, halted},      32'd0);
        check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
        check("rst_stall",   {26'd0, stall_cycles}, 32'd0);
        check("rst_flush",   {26'd0, flush_count},  32'd0);
        check("rst_pc",      {31'd0, pc_stall},     32'd0);
        check("rst_bubble",  {31'd0, mem_wb_bubble}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_use_r5();
        idle();
        ex_mem_rd = 1'b1; ex_wr = 1'b1; ex_reg_dst = 4'd5;
        id_rs2 = 4'd5; id_rs2_used = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Load-use on r5, then the same pattern on r0
        load_use_r5(); step();
        idle(); step();
        check("lu_stall_cnt", {26'd0, stall_cycles}, 32'd1);
        load_use_r5(); ex_reg_dst = 4'd0; id_rs2 = 4'd0; step();
        idle(); step();
        check("lu_r0_stall_cnt", {26'd0, stall_cycles}, 32'd1);

        // Branch and load-use together
        do_reset();
        load_use_r5(); ex_branch_taken = 1'b1; step();
        idle(); step();
        check("br_flush_cnt", {26'd0, flush_count}, 32'd1);
        check("br_stall_cnt", {26'd0, stall_cycles}, 32'd0);

        // Three-cycle memory wait
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); mem_req = 1'b1; step();
        end
        mem_req = 1'b1; mem_ready = 1'b1; step();
        idle(); step();
        check("mw_stall_cnt", {26'd0, stall_cycles}, 32'd3);

        // Branch held through a two-cycle freeze
        do_reset();
        for (int i = 0; i < 2; i++) begin
            idle(); mem_req = 1'b1; ex_branch_taken = 1'b1; step();
        end
        mem_ready = 1'b1; step();
        idle(); step();
        check("held_br_flush_cnt", {26'd0, flush_count}, 32'd1);

        // Memory timeout, then reset while halted
        do_reset();
        idle(); mem_req = 1'b1;
        for (int i = 0; i < TMO + 3; i++) step();
        check("tmo_flag",   {31'd0, mem_timeout}, 32'd1);
        check("tmo_halted", {31'd0, halted},      32'd1);
        check("tmo_stall",  {31'd0, pc_stall},    32'd1);
        idle(); step(); step();
        do_reset();

        // Halt pulse, idle, then reset in the middle of a memory wait
        idle(); wb_halt = 1'b1; step();
        idle(); step(); step();
        check("halt_persist", {31'd0, halted}, 32'd1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); mem_req = 1'b1; step();
        end
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            id_rs1          = REG_W'($urandom_range(0, 3));
            id_rs2          = REG_W'($urandom_range(0, 3));
            ex_reg_dst      = REG_W'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            ex_wr           = ($urandom_range(0, 3) != 0);
            ex_mem_rd       = 1'($urandom_range(0, 1));
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_req         = ($urandom_range(0, 9) < 4);
            mem_ready       = ($urandom_range(0, 9) < 6);
            wb_halt         = ($urandom_range(0, 299) == 0);
            if ((m_halt && $urandom_range(0, 19) == 0) || $urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Pipeline sequencing controller for the 5-stage CPU. It detects load-use hazards that the EX-stage forwarding path cannot cover, freezes the pipeline during multi-cycle data-memory accesses, and flushes wrong-path instructions on taken branches. It also handles program halt and memory timeout, and keeps saturating stall/flush performance counters.
Sits beside the forwarding unit and drives the stall/flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

Parameters:
REG_W, 4, register address width (16 architectural registers)
R0_ZERO, 1, when 1, register 0 is hardwired and never creates a hazard
MEM_TIMEOUT, 255, maximum consecutive mem_ready-low cycles before timeout (8-bit wait counter)
CNT_W, 16, width of the performance counters

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
id_rs1  input  REG_W  ID-stage source register 1
id_rs2  input  REG_W  ID-stage source register 2
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_reg_dst  input  REG_W  EX-stage destination register
ex_wr  input  1  EX instruction writes the register file
ex_mem_rd  input  1  EX instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch/jump
mem_req  input  1  MEM stage has a data-memory access this cycle
mem_ready  input  1  data memory completes the access this cycle
wb_halt  input  1  halt instruction is in WB
pc_stall  output  1  hold PC
if_id_stall  output  1  hold IF/ID
if_id_flush  output  1  clear IF/ID to NOP
id_ex_stall  output  1  hold ID/EX
id_ex_flush  output  1  load NOP into ID/EX
ex_mem_stall  output  1  hold EX/MEM
mem_wb_bubble  output  1  load NOP into MEM/WB
halted  output  1  core halted (registered)
mem_timeout  output  1  sticky memory-timeout error (registered)
stall_cycles  output  CNT_W  saturating count of cycles with pc_stall=1 outside HALT
flush_count  output  CNT_W  saturating count of branch-flush cycles

Behaviour:
- Reset is asynchronous: state=RUN, wait counter=0, halted=0, mem_timeout=0, both counters=0. Reset mid-wait abandons the access with no error.
- FSM states: RUN, MEM_WAIT, HALT. The state is registered; the control outputs are combinational from state and inputs, so control takes effect in the same cycle.
- freeze = (mem_req && !mem_ready) in RUN/MEM_WAIT. While freeze is high: pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=mem_wb_bubble=1, and all flush outputs are 0 (the branch is held in frozen EX and applied on release).
- load_use = ex_mem_rd && ex_wr && !(R0_ZERO && ex_reg_dst==0) && ((id_rs1_used && id_rs1==ex_reg_dst) || (id_rs2_used && id_rs2==ex_reg_dst)).
- Priority when not frozen:
  - ex_branch_taken: if_id_flush=1 and id_ex_flush=1, with no stall. The branch beats load-use because the dependent instruction is wrong-path.
  - else load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly one cycle. On the next cycle the load is in MEM and forwarding covers the dependence.
  - else all outputs are 0.
- RUN -> MEM_WAIT when freeze is high. The wait counter loads 1.
- MEM_WAIT: the counter increments each cycle mem_ready=0.
  - On mem_ready=1, freeze drops that cycle, the RUN priority rules apply in the same cycle, and the FSM returns to RUN next cycle.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0: go to HALT next cycle and set mem_timeout=1 (sticky).
- A single-cycle access (mem_req && mem_ready) causes no freeze and no state change.
- wb_halt=1 in RUN or MEM_WAIT -> HALT next cycle, and halted=1 from that cycle. wb_halt has priority over the freeze transition.
- HALT: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_bubble are all 1, and flushes are 0. HALT exits only on reset. Counters do not increment in HALT.
- stall_cycles increments on every non-HALT cycle with pc_stall=1 (freeze or load-use). flush_count increments on every cycle with if_id_flush=1. Both saturate at all-ones and never wrap.

Test Plan:
- Load-use: ex_mem_rd=1, ex_wr=1, ex_reg_dst=5, id_rs2=5, id_rs2_used=1 -> for one cycle pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles=1. Repeat with ex_reg_dst=0 -> no stall.
- Branch plus load-use in the same cycle: ex_branch_taken=1 with the load-use condition above -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_count=1, stall_cycles=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> four-stage freeze plus mem_wb_bubble for 3 cycles, released on cycle 4; state returns to RUN; stall_cycles=3.
- Freeze with held branch: ex_branch_taken=1 during a 2-cycle wait -> no flush while frozen; flush occurs on the release cycle only; flush_count=1.
- Timeout: mem_req=1, mem_ready=0 held -> after 255 wait cycles, HALT; mem_timeout=1, halted=1; all stalls remain asserted thereafter.
- Halt and reset: pulse wb_halt -> halted=1 next cycle, persists with inputs idle. Assert rst_n=0 mid-HALT or mid-MEM_WAIT -> all outputs and counters return to 0 immediately.
